decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I decode pipeline stage that drives the ALU interface.
- Takes fetched instruction, PC and register-file read data.
- Produces alu_control, operand_a, operand_b, immediate and writeback/branch control, using the ALU's 4-bit control encoding.
- Valid/ready on both sides, one output register plus one skid register; sits between fetch/regfile read and execute.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- NOP_ON_ILLEGAL, 1, when 1 an undecodable instruction is issued as a bubble-equivalent NOP (ADD, reg_write=0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_rs1_data  in  32  rs1 register value.
- in_rs2_data  in  32  rs2 register value.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts.
- out_alu_control  out  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 BEQ=A BNE=B BLT=C BGE=D BLTU=E BGEU=F.
- out_operand_a  out  32  ALU operand A.
- out_operand_b  out  32  ALU operand B.
- out_imm  out  32  sign-extended immediate (branch/jump target offset, store offset).
- out_pc  out  32  PC of the instruction.
- out_rd  out  5  destination register.
- out_reg_write  out  1  writeback enable.
- out_is_branch  out  1  conditional branch.
- out_is_jump  out  1  JAL/JALR.
- out_illegal  out  1  illegal flag (see Optional Feature).

Behaviour:
- Reset: all outputs 0, out_valid=0, skid_valid=0, hence in_ready=1.
- Latency: an instruction accepted on cycle N (in_valid&in_ready) appears on out_* at N+1.
- Transfer occurs when valid&ready. out_* hold stable while out_valid&!out_ready.
- Skid: if the output register is full and not draining, an accepted instruction goes to the skid register.
  - in_ready drops the next cycle.
  - On drain, skid moves to output and in_ready rises the following cycle.
  - Simultaneous drain + accept with empty skid: new instruction loads the output directly.
- Program order is always preserved.

Decode by opcode (rd==0 forces reg_write=0):
- OP 0110011: funct3 000→ADD/SUB by funct7[5], 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND. a=rs1, b=rs2, reg_write=1.
- OP-IMM 0010011: same map, but 000 is always ADD; 101 uses imm[10] for SRA. b=I-imm.
- LOAD 0000011: ADD, a=rs1, b=I-imm, reg_write=1.
- STORE 0100011: ADD, a=rs1, b=S-imm, imm=S-imm, reg_write=0.
- BRANCH 1100011: f3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. a=rs1, b=rs2, imm=B-imm, is_branch=1. f3 010/011 are illegal.
- LUI 0110111: ADD, a=0, b=U-imm.
- AUIPC 0010111: ADD, a=pc, b=U-imm.
- JAL 1101111: ADD, a=pc, b=4, imm=J-imm, is_jump=1.
- JALR 1100111: ADD, a=pc, b=4, imm=I-imm, is_jump=1.
- Any other opcode is illegal and is issued as a NOP: ADD, a=b=0, reg_write=0, branch=jump=0.

Flush:
- Clears out_valid and skid_valid on the next edge.
- An instruction presented in the flush cycle is dropped.
- flush overrides all other updates in that cycle.

Reset mid-transfer discards all in-flight data asynchronously.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- When defined:
  - out_illegal=1 for illegal opcodes, illegal branch funct3, and OP with funct7 not in {0000000, 0100000}.
  - Such instructions keep reg_write=0.
  - The stage stops accepting (in_ready=0) once an illegal instruction has been accepted, until flush.
- When not defined: out_illegal is tied 0, illegal instructions become NOPs, and there is no stall.

Test Plan:
- Reset release; in_instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 → next cycle: out_valid=1, ctrl=0x0, a=5, b=7, rd=3, reg_write=1.
- 0x402081B3 (sub), then 0x40335293 (srai x5,x6,3) back-to-back → ctrl 0x1, then ctrl 0x7 with b=3 (immediate shamt; 0x403 read as SRA).
- 0x00C0C463 (blt x1,x12,+8) → ctrl 0xC, is_branch=1, imm=8, reg_write=0. 0x123453B7 (lui x7) → a=0, b=0x12345000.
- out_ready=0 for 3 cycles while sending 3 instructions → in_ready drops after the 2nd is accepted; all 3 emerge in order, none lost.
- flush asserted with output and skid full → out_valid=0 next cycle, in_ready=1, skid contents never appear.
- opcode 0x7F: with the macro, out_illegal=1 and in_ready stays 0 until flush; without it, a NOP with reg_write=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage feeding the ALU.
// Decodes a fetched instruction together with its PC and register-file read
// data into an ALU control code, two operands, an immediate and
// writeback/branch/jump flags. Upstream and downstream are valid/ready
// handshakes; one output register plus one skid register decouple them.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   defined   - illegal instructions raise out_illegal and stall intake until flush
//   undefined - out_illegal stays 0, illegal instructions become NOPs, no stall
module decode_stage #(
  parameter int XLEN           = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_control,
  output logic [XLEN-1:0] out_operand_a,
  output logic [XLEN-1:0] out_operand_b,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_illegal
);

  // ALU control encoding shared with the execute stage
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_BEQ  = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALU_BLT  = 4'hC;
  localparam logic [3:0] ALU_BGE  = 4'hD;
  localparam logic [3:0] ALU_BLTU = 4'hE;
  localparam logic [3:0] ALU_BGEU = 4'hF;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Everything the execute stage needs for one instruction
  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
  } dec_t;

  // funct3 -> ALU op for OP / OP-IMM; alt selects SUB (register form only) or SRA
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Full instruction decode; illegal encodings collapse to a NOP bubble
  function automatic dec_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc,
                                  input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    dec_t            d;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            bad;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] shamt;

    opcode = instr[6:0];
    f3     = instr[14:12];
    bad    = 1'b0;
    imm_i  = {{20{instr[31]}}, instr[31:20]};
    imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u  = {instr[31:12], 12'b0};
    imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Shift immediates carry only the 5-bit shamt; bit 30 is the SRA selector
    shamt  = {27'b0, instr[24:20]};

    d      = '0;
    d.pc   = pc;
    d.ctrl = ALU_ADD;

    case (opcode)
      OPC_OP: begin
        d.ctrl      = alu_op(f3, instr[30], 1'b1);
        d.a         = rs1;
        d.b         = rs2;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000) bad = 1'b1;
`endif
      end
      OPC_OP_IMM: begin
        d.ctrl      = alu_op(f3, instr[30], 1'b0);
        d.a         = rs1;
        d.b         = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
        d.imm       = imm_i;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        d.a         = rs1;
        d.b         = imm_i;
        d.imm       = imm_i;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OPC_STORE: begin
        d.a   = rs1;
        d.b   = imm_s;
        d.imm = imm_s;
      end
      OPC_BRANCH: begin
        d.a         = rs1;
        d.b         = rs2;
        d.imm       = imm_b;
        d.is_branch = 1'b1;
        case (f3)
          3'b000:  d.ctrl = ALU_BEQ;
          3'b001:  d.ctrl = ALU_BNE;
          3'b100:  d.ctrl = ALU_BLT;
          3'b101:  d.ctrl = ALU_BGE;
          3'b110:  d.ctrl = ALU_BLTU;
          3'b111:  d.ctrl = ALU_BGEU;
          default: bad    = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d.b         = imm_u;
        d.imm       = imm_u;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d.a         = pc;
        d.b         = imm_u;
        d.imm       = imm_u;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
      end
      OPC_JAL: begin
        d.a         = pc;
        d.b         = 32'd4;
        d.imm       = imm_j;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
        d.is_jump   = 1'b1;
      end
      OPC_JALR: begin
        d.a         = pc;
        d.b         = 32'd4;
        d.imm       = imm_i;
        d.rd        = instr[11:7];
        d.reg_write = 1'b1;
        d.is_jump   = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // An illegal instruction never writes back, branches or jumps
    if (bad) begin
      if (NOP_ON_ILLEGAL) begin
        d.ctrl = ALU_ADD;
        d.a    = '0;
        d.b    = '0;
        d.imm  = '0;
        d.rd   = '0;
      end
      d.reg_write = 1'b0;
      d.is_branch = 1'b0;
      d.is_jump   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      d.illegal   = 1'b1;
`endif
    end

    // x0 is hard-wired to zero, so a write to it is dropped here
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    return d;
  endfunction

  dec_t dec_p0;
  dec_t out_p1;
  dec_t skid_p1;
  logic vld_p1;
  logic skid_vld_p1;
  logic in_fire;
  logic out_free;

  // ---- stage p0: combinational decode of the incoming instruction ----
  // Decode the upstream bundle every cycle; it is only captured on acceptance
  always_comb begin
    dec_p0 = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic trap_hold;

  // Once an illegal instruction has been accepted, hold off intake until flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_hold <= 1'b0;
    end else if (flush) begin
      trap_hold <= 1'b0;
    end else if (in_fire && dec_p0.illegal) begin
      trap_hold <= 1'b1;
    end
  end

  assign in_ready = !skid_vld_p1 && !trap_hold;
`else
  assign in_ready = !skid_vld_p1;
`endif

  assign in_fire  = in_valid && in_ready;
  // Output register can take new content when empty or being drained this cycle
  assign out_free = !vld_p1 || out_ready;

  // ---- stage p1: output register and skid register ----
  // Valid bookkeeping: skid refills the output first, so program order holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_p1) begin
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else begin
        vld_p1      <= in_fire;
      end
    end else if (in_fire) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Output data: load from skid if occupied, else straight from the decoder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
    end else if (!flush && out_free) begin
      if (skid_vld_p1) begin
        out_p1 <= skid_p1;
      end else if (in_fire) begin
        out_p1 <= dec_p0;
      end
    end
  end

  // Skid data: captures an accepted instruction while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_p1 <= '0;
    end else if (!flush && !out_free && in_fire) begin
      skid_p1 <= dec_p0;
    end
  end

  assign out_valid       = vld_p1;
  assign out_alu_control = out_p1.ctrl;
  assign out_operand_a   = out_p1.a;
  assign out_operand_b   = out_p1.b;
  assign out_imm         = out_p1.imm;
  assign out_pc          = out_p1.pc;
  assign out_rd          = out_p1.rd;
  assign out_reg_write   = out_p1.reg_write;
  assign out_is_branch   = out_p1.is_branch;
  assign out_is_jump     = out_p1.is_jump;
  assign out_illegal     = out_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model computed from the RV32I decode rules.
// Honours DECODE_ILLEGAL_TRAP_EN the same way the design does.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_control;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_is_branch;
  logic        out_is_jump;
  logic        out_illegal;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_control(out_alu_control), .out_operand_a(out_operand_a),
    .out_operand_b(out_operand_b), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        jp;
    logic        ill;
  } exp_t;

  exp_t       q[$];
  bit         trap_m;
  int         errors;
  int         checks;
  logic [3:0] optab [8];
  logic [3:0] brtab [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference decode built from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] iimm, simm, bimm, uimm, jimm;
    logic [12:0] btmp;
    logic [20:0] jtmp;
    bit          illegal;
    f3      = ins[14:12];
    iimm    = $signed(ins) >>> 20;
    simm    = {iimm[31:5], ins[11:7]};
    btmp    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    bimm    = 32'($signed(btmp));
    uimm    = ins & 32'hFFFF_F000;
    jtmp    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    jimm    = 32'($signed(jtmp));
    illegal = 0;
    e = '{ctrl: 4'h0, a: 32'h0, b: 32'h0, imm: 32'h0, pc: pc, rd: 5'h0,
          rw: 1'b0, br: 1'b0, jp: 1'b0, ill: 1'b0};
    case (ins[6:0])
      7'h33: begin
        e.ctrl = optab[f3] + {3'b0, ((f3 == 3'd0 || f3 == 3'd5) && ins[30])};
        e.a = r1; e.b = r2; e.rd = ins[11:7]; e.rw = 1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (ins[31:25] != 7'h00 && ins[31:25] != 7'h20) illegal = 1;
`endif
      end
      7'h13: begin
        e.ctrl = optab[f3] + {3'b0, (f3 == 3'd5 && ins[30])};
        e.a = r1; e.imm = iimm; e.rd = ins[11:7]; e.rw = 1;
        e.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, ins[24:20]} : iimm;
      end
      7'h03: begin e.a = r1; e.b = iimm; e.imm = iimm; e.rd = ins[11:7]; e.rw = 1; end
      7'h23: begin e.a = r1; e.b = simm; e.imm = simm; end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) illegal = 1;
        else begin e.ctrl = brtab[f3]; e.a = r1; e.b = r2; e.imm = bimm; e.br = 1; end
      end
      7'h37: begin e.b = uimm; e.imm = uimm; e.rd = ins[11:7]; e.rw = 1; end
      7'h17: begin e.a = pc; e.b = uimm; e.imm = uimm; e.rd = ins[11:7]; e.rw = 1; end
      7'h6F: begin e.a = pc; e.b = 4; e.imm = jimm; e.rd = ins[11:7]; e.rw = 1; e.jp = 1; end
      7'h67: begin e.a = pc; e.b = 4; e.imm = iimm; e.rd = ins[11:7]; e.rw = 1; e.jp = 1; end
      default: illegal = 1;
    endcase
    if (illegal) begin
      e = '{ctrl: 4'h0, a: 32'h0, b: 32'h0, imm: 32'h0, pc: pc, rd: 5'h0,
            rw: 1'b0, br: 1'b0, jp: 1'b0, ill: 1'b0};
`ifdef DECODE_ILLEGAL_TRAP_EN
      e.ill = 1;
`endif
    end
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  bad_ops [5];
    int          sel;
    bad_ops = '{7'h7F, 7'h0F, 7'h73, 7'h2F, 7'h00};
    w   = $urandom();
    sel = $urandom_range(0, 11);
    case (sel)
      0, 1, 11: begin
        w[6:0] = 7'h33;
        if ($urandom_range(0, 9) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      end
      2:  w[6:0] = 7'h13;
      3:  w[6:0] = 7'h03;
      4:  w[6:0] = 7'h23;
      5:  w[6:0] = 7'h63;
      6:  w[6:0] = 7'h37;
      7:  w[6:0] = 7'h17;
      8:  w[6:0] = 7'h6F;
      9:  w[6:0] = 7'h67;
      default: w[6:0] = bad_ops[$urandom_range(0, 4)];
    endcase
    return w;
  endfunction

  // One clock: advance the model with the driven inputs, then compare
  task automatic cycle();
    exp_t nd;
    bit   acc;
    bit   drn;
    acc = in_valid && (q.size() < 2) && !trap_m;
    drn = (q.size() > 0) && out_ready;
    nd  = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
    @(posedge clk);
    if (flush) begin
      q.delete();
      trap_m = 0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(nd);
        if (nd.ill) trap_m = 1;
      end
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2 && !trap_m));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("ctrl", 32'(out_alu_control), 32'(q[0].ctrl));
      chk("operand_a", out_operand_a, q[0].a);
      chk("operand_b", out_operand_b, q[0].b);
      chk("imm", out_imm, q[0].imm);
      chk("pc", out_pc, q[0].pc);
      chk("rd", 32'(out_rd), 32'(q[0].rd));
      chk("reg_write", 32'(out_reg_write), 32'(q[0].rw));
      chk("is_branch", 32'(out_is_branch), 32'(q[0].br));
      chk("is_jump", 32'(out_is_jump), 32'(q[0].jp));
      chk("illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  initial begin
    optab = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
    brtab = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hD, 4'hE, 4'hF};
    errors = 0; checks = 0; trap_m = 0;
    clk = 0; rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    drive(32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_operand_a", out_operand_a, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_reg_write", 32'(out_reg_write), 32'h0);
    rst_n = 1;
    cycle();

    // add x3,x1,x2
    in_valid = 1;
    drive(32'h002081B3, 32'h0000_0040, 32'd5, 32'd7);
    cycle();
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_ctrl", 32'(out_alu_control), 32'h0);
    chk("add_a", out_operand_a, 32'd5);
    chk("add_b", out_operand_b, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_rw", 32'(out_reg_write), 32'h1);

    // sub then srai back to back
    drive(32'h402081B3, 32'h0000_0044, 32'd9, 32'd4);
    cycle();
    chk("sub_ctrl", 32'(out_alu_control), 32'h1);
    drive(32'h40335293, 32'h0000_0048, 32'hF000_0000, 32'd0);
    cycle();
    chk("srai_ctrl", 32'(out_alu_control), 32'h7);
    chk("srai_b", out_operand_b, 32'd3);

    // blt and lui
    drive(32'h00C0C463, 32'h0000_004C, 32'd1, 32'd2);
    cycle();
    chk("blt_ctrl", 32'(out_alu_control), 32'hC);
    chk("blt_branch", 32'(out_is_branch), 32'h1);
    chk("blt_imm", out_imm, 32'd8);
    chk("blt_rw", 32'(out_reg_write), 32'h0);
    drive(32'h123453B7, 32'h0000_0050, 32'hDEAD_BEEF, 32'h1);
    cycle();
    chk("lui_a", out_operand_a, 32'h0);
    chk("lui_b", out_operand_b, 32'h1234_5000);

    // Back-pressure: three instructions while execute stalls
    in_valid = 0;
    cycle();
    out_ready = 0; in_valid = 1;
    drive(32'h002081B3, 32'h0000_0100, 32'd1, 32'd1);
    cycle();
    drive(32'h402081B3, 32'h0000_0104, 32'd2, 32'd2);
    cycle();
    chk("skid_in_ready_low", 32'(in_ready), 32'h0);
    drive(32'h0020C1B3, 32'h0000_0108, 32'd3, 32'd3);
    cycle();
    chk("stall_hold_pc", out_pc, 32'h0000_0100);
    out_ready = 1;
    cycle();
    chk("drain1_pc", out_pc, 32'h0000_0104);
    cycle();
    chk("drain2_pc", out_pc, 32'h0000_0108);
    in_valid = 0;
    cycle();
    chk("drain_empty", 32'(out_valid), 32'h0);

    // Flush with output and skid occupied
    out_ready = 0; in_valid = 1;
    drive(32'h002081B3, 32'h0000_0200, 32'd4, 32'd4);
    cycle();
    drive(32'h00C0C463, 32'h0000_0204, 32'd5, 32'd5);
    cycle();
    flush = 1;
    drive(32'h123453B7, 32'h0000_0208, 32'd6, 32'd6);
    cycle();
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) begin
      cycle();
      chk("flush_no_ghost", 32'(out_valid), 32'h0);
    end

    // Undecodable opcode 0x7F
    in_valid = 1;
    drive(32'h0000037F, 32'h0000_0300, 32'd11, 32'd12);
    cycle();
    chk("ill_valid", 32'(out_valid), 32'h1);
    chk("ill_rw", 32'(out_reg_write), 32'h0);
    chk("ill_ctrl", 32'(out_alu_control), 32'h0);
    chk("ill_a", out_operand_a, 32'h0);
    chk("ill_b", out_operand_b, 32'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(out_illegal), 32'h1);
    chk("ill_stall", 32'(in_ready), 32'h0);
    drive(32'h002081B3, 32'h0000_0304, 32'd1, 32'd1);
    repeat (2) begin
      cycle();
      chk("ill_stall_hold", 32'(in_ready), 32'h0);
    end
    flush = 1;
    cycle();
    flush = 0;
    chk("ill_flush_ready", 32'(in_ready), 32'h1);
`else
    chk("ill_flag", 32'(out_illegal), 32'h0);
    chk("ill_no_stall", 32'(in_ready), 32'h1);
`endif
    in_valid = 0;
    cycle();

    // Asynchronous reset with both registers full
    out_ready = 0; in_valid = 1;
    drive(32'h002081B3, 32'h0000_0400, 32'd1, 32'd2);
    cycle();
    drive(32'h402081B3, 32'h0000_0404, 32'd3, 32'd4);
    cycle();
    in_valid = 0;
    #3 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_pc", out_pc, 32'h0);
    q.delete();
    trap_m = 0;
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      drive(rand_instr(), $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom());
      cycle();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
